// File: rtl/shared_reg_pkg.sv
// Shared definitions for the shared-register write arbiter: FSM encoding,
// data/client limits and internal counter widths.
package shared_reg_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned MAX_CLIENTS = 8;
  // Wide enough to index MAX_CLIENTS clients.
  localparam int unsigned PTR_W       = 3;
  // Wide enough for TIMEOUT_CYCLES up to 255.
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    RELEASE   = 2'd2,
    WAIT_FULL = 2'd3
  } state_e;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: searches from pointer+1 upward with wrap
// and returns the first asserted request as an index and a one-hot vector.
module rr_select
  import shared_reg_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [PTR_W-1:0]       pointer,
  output logic                   valid,
  output logic [PTR_W-1:0]       w,
  output logic [NUM_CLIENTS-1:0] onehot
);

  // Offset-major scan keeps every req index constant so no variable selects.
  always_comb begin
    valid  = 1'b0;
    w      = '0;
    onehot = '0;
    for (int unsigned off = 1; off <= NUM_CLIENTS; off++) begin
      for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
        if (!valid && req[j] && (j == ((32'(pointer) + off) % NUM_CLIENTS))) begin
          valid     = 1'b1;
          w         = PTR_W'(j);
          onehot[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shared_reg_write_arbiter.sv
// Round-robin arbiter sharing the single write port of the 1-byte shared
// register among several writer clients. Drives the wr level handshake,
// waits for has_data, acknowledges the owner or aborts on timeout.
module shared_reg_write_arbiter
  import shared_reg_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [NUM_CLIENTS-1:0]        req,
  input  logic [DATA_W*NUM_CLIENTS-1:0] req_data,
  output logic [NUM_CLIENTS-1:0]        ack,
  output logic [NUM_CLIENTS-1:0]        grant,
  output logic                          busy,
  output logic                          err,
  input  logic                          reg_has_data,
  output logic                          reg_wr,
  output logic [DATA_W-1:0]             reg_wr_data
);

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_CLIENTS-1:0]  ack_q, ack_d;
  logic [NUM_CLIENTS-1:0]  grant_q, grant_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic                    reg_wr_q, reg_wr_d;
  logic [DATA_W-1:0]       wr_data_q, wr_data_d;

  logic                    sel_valid;
  logic [PTR_W-1:0]        sel_w;
  logic [NUM_CLIENTS-1:0]  sel_onehot;
  logic [DATA_W-1:0]       sel_data;
  logic                    start;
  logic                    timeout_hit;

  rr_select #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_rr_select (
    .req     (req),
    .pointer (ptr_q),
    .valid   (sel_valid),
    .w       (sel_w),
    .onehot  (sel_onehot)
  );

  // Byte of the current round-robin winner.
  always_comb begin
    sel_data = '0;
    for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
      if (PTR_W'(j) == sel_w) sel_data = req_data[j*DATA_W +: DATA_W];
    end
  end

  assign start       = sel_valid && !reg_has_data;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = WRITE;
      WRITE:     state_d = RELEASE;
      RELEASE:   state_d = WAIT_FULL;
      WAIT_FULL: if (reg_has_data || timeout_hit) state_d = IDLE;
    endcase
  end

  // Next values for datapath and output registers.
  always_comb begin
    ack_d     = '0;
    grant_d   = grant_q;
    err_d     = err_q;
    reg_wr_d  = 1'b0;
    wr_data_d = wr_data_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    busy_d    = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          wr_data_d = sel_data;
          grant_d   = sel_onehot;
          owner_d   = sel_w;
          reg_wr_d  = 1'b1;
        end
      end
      WRITE: ;
      RELEASE: cnt_d = '0;
      WAIT_FULL: begin
        if (reg_has_data) begin
          ack_d   = grant_q;
          grant_d = '0;
          ptr_d   = owner_q;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          grant_d = '0;
          ptr_d   = owner_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ack_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      reg_wr_q  <= 1'b0;
      wr_data_q <= '0;
      ptr_q     <= PTR_W'(NUM_CLIENTS - 1);
      owner_q   <= '0;
      cnt_q     <= '0;
    end else begin
      ack_q     <= ack_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      reg_wr_q  <= reg_wr_d;
      wr_data_q <= wr_data_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ack         = ack_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign reg_wr      = reg_wr_q;
  assign reg_wr_data = wr_data_q;

endmodule

// File: tb/tb_shared_reg_write_arbiter.sv
// Bench for shared_reg_write_arbiter: behavioural mailbox register plus a
// transaction-timing reference model; directed phases and a random phase.
module tb_shared_reg_write_arbiter;

  localparam int N   = 4;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        busy;
  logic        err;
  logic        reg_has_data;
  logic        reg_wr;
  logic [7:0]  reg_wr_data;

  // mailbox register model and reader
  logic        hd, pend, rd_seen, stub, auto_read;
  logic [7:0]  mb;
  byte unsigned rx_q[$];
  byte unsigned exp_q[$];
  int          obs_ack[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // reference model state
  bit          m_idle;
  bit          m_err;
  int          m_w, m_last, m_t0;
  logic [7:0]  m_data;
  logic [3:0]  e_ack, e_grant;

  shared_reg_write_arbiter #(
    .NUM_CLIENTS    (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .grant        (grant),
    .busy         (busy),
    .err          (err),
    .reg_has_data (reg_has_data),
    .reg_wr       (reg_wr),
    .reg_wr_data  (reg_wr_data)
  );

  always #5 clk = ~clk;

  assign reg_has_data = stub ? 1'b0 : hd;

  // 1-byte mailbox: capture on wr high, has_data after wr drops,
  // reader takes the byte then clears has_data on the following edge.
  always @(posedge clk) begin
    if (!nrst) begin
      hd <= 1'b0; pend <= 1'b0; rd_seen <= 1'b0;
    end else begin
      if (reg_wr && !hd && !pend && !stub) begin
        mb <= reg_wr_data; pend <= 1'b1;
      end else if (pend && !reg_wr) begin
        hd <= 1'b1; pend <= 1'b0;
      end
      if (rd_seen) begin
        hd <= 1'b0; rd_seen <= 1'b0;
      end else if (auto_read && hd) begin
        rx_q.push_back(mb); rd_seen <= 1'b1;
      end
    end
  end

  function automatic int rr_pick(logic [3:0] r, int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (((r >> c) & 4'b1) != 4'b0) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: model predicts from pre-edge inputs, outputs checked #1 after.
  task automatic step();
    logic [3:0]  rp;
    logic        hp, np;
    logic [31:0] dp;
    rp = req; hp = reg_has_data; np = nrst; dp = req_data;
    @(posedge clk);
    #1;
    cyc++;
    e_ack = 4'b0;
    if (!np) begin
      m_idle = 1'b1; m_last = N - 1; m_err = 1'b0; m_data = 8'h00;
    end else if (!m_idle) begin
      if (cyc >= m_t0 + 3 && hp) begin
        e_ack = 4'(1 << m_w); m_last = m_w; m_idle = 1'b1;
        exp_q.push_back(m_data);
      end else if (cyc == m_t0 + 2 + TMO) begin
        m_err = 1'b1; m_last = m_w; m_idle = 1'b1;
      end
    end else if (rp != 4'b0 && !hp) begin
      m_w = rr_pick(rp, m_last); m_t0 = cyc; m_idle = 1'b0;
      m_data = 8'(dp >> (8 * m_w));
    end
    e_grant = m_idle ? 4'b0 : 4'(1 << m_w);
    chk("grant", 32'(grant), 32'(e_grant));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("busy", 32'(busy), 32'(!m_idle));
    chk("err", 32'(err), 32'(m_err));
    chk("reg_wr", 32'(reg_wr), 32'(!m_idle && cyc == m_t0));
    chk("reg_wr_data", 32'(reg_wr_data), 32'(m_data));
    for (int i = 0; i < N; i++) if (((ack >> i) & 4'b1) != 4'b0) obs_ack.push_back(i);
    req = req & ~e_ack;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_data(input int c, input logic [7:0] b);
    req_data = (req_data & ~(32'hFF << (8 * c))) | (32'(b) << (8 * c));
  endtask

  task automatic clear_logs();
    rx_q.delete(); exp_q.delete(); obs_ack.delete();
  endtask

  task automatic cmp_rx_exp(input string tag);
    chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      chk(tag, 32'(rx_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_order[5];
    byte unsigned exp_rx[5];
    exp_order = '{0, 1, 2, 3, 0};
    exp_rx    = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

    m_idle = 1'b1; m_err = 1'b0; m_last = N - 1; m_w = 0; m_t0 = 0; m_data = 8'h00;
    nrst = 1'b0; req = 4'b1111; req_data = 32'h13121110;
    stub = 1'b0; auto_read = 1'b1;

    // Reset with all requesting, then round-robin with immediate draining.
    clear_logs();
    run(3);
    nrst = 1'b1;
    step();
    chk("grant_after_reset", 32'(grant), 32'h1);
    run(21);
    req = 4'b0001;
    run(8);
    chk("rr_order_len", 32'(obs_ack.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs_ack.size(); i++) chk("rr_order", 32'(obs_ack[i]), 32'(exp_order[i]));
    chk("rr_rx_len", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("rr_rx", 32'(rx_q[i]), 32'(exp_rx[i]));

    // Single write, reader idle so the byte stays in the register.
    clear_logs();
    auto_read = 1'b0;
    set_data(2, 8'hA5);
    req = 4'b0100;
    step();
    chk("single_wr", 32'(reg_wr), 32'h1);
    chk("single_wr_data", 32'(reg_wr_data), 32'hA5);
    run(5);
    chk("single_mb_data", 32'(mb), 32'hA5);
    chk("single_has_data", 32'(hd), 32'h1);

    // Blocked while the register is full, granted once the reader drains it.
    set_data(1, 8'h3C);
    req = 4'b0010;
    run(20);
    chk("blocked_busy", 32'(busy), 32'h0);
    chk("blocked_grant", 32'(grant), 32'h0);
    auto_read = 1'b1;
    run(10);

    // Random traffic with a randomly stalling reader.
    clear_logs();
    for (int s = 0; s < 300; s++) begin
      auto_read = 1'($urandom_range(1));
      for (int i = 0; i < N; i++) begin
        if (((req >> i) & 4'b1) == 4'b0 && $urandom_range(3) == 0) begin
          set_data(i, 8'($urandom));
          req = req | 4'(1 << i);
        end
      end
      step();
    end
    auto_read = 1'b1;
    run(40);
    cmp_rx_exp("rand_rx");

    // Timeout: has_data never rises.
    stub = 1'b1;
    set_data(3, 8'h77);
    req = 4'b1000;
    run(TMO + 3);
    chk("timeout_err", 32'(err), 32'h1);
    chk("timeout_grant", 32'(grant), 32'h0);
    req = 4'b0000;
    run(3);
    chk("err_sticky", 32'(err), 32'h1);
    stub = 1'b0;
    req = 4'b0010;
    run(10);
    chk("err_sticky_after_write", 32'(err), 32'h1);

    // Reset while in WRITE; client 0 wins afterwards.
    req = 4'b0100;
    step();
    chk("midreset_grant_pre", 32'(grant), 32'h4);
    nrst = 1'b0;
    req = 4'b0111;
    step();
    chk("midreset_reg_wr", 32'(reg_wr), 32'h0);
    chk("midreset_grant", 32'(grant), 32'h0);
    nrst = 1'b1;
    step();
    chk("midreset_priority", 32'(grant), 32'h1);
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
